// File: rtl/banco_registradores.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | banco_registradores: signed register file with registered operand   |
// | capture, write-first bypass, R0 = 0 and adder-result status flags.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module banco_registradores #(
  parameter int LARGURA = 8,
  parameter int NREG    = 8,
  parameter int ENDW    = 3
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [ENDW-1:0]    EndLeitura1,
  input  logic [ENDW-1:0]    EndLeitura2,
  input  logic               LeituraEn,
  input  logic [ENDW-1:0]    EndEscrita,
  input  logic               Escrita,
  input  logic [LARGURA-1:0] DadoEscrita,
  input  logic               FlagsEn,
  output logic [LARGURA-1:0] Operando1,
  output logic [LARGURA-1:0] Operando2,
  output logic               OperandosValidos,
  output logic               FlagZero,
  output logic               FlagNegativo,
  output logic               FlagOverflow
);

  localparam logic [ENDW-1:0] c_end_zero = '0;

  logic [LARGURA-1:0] r_regs [NREG];
  logic [LARGURA-1:0] r_op1;
  logic [LARGURA-1:0] r_op2;
  logic               r_validos;
  logic               r_zero;
  logic               r_neg;
  logic               r_ovf;
  logic [LARGURA-1:0] w_val1;
  logic [LARGURA-1:0] w_val2;
  logic               w_escreve;
  logic               w_ovf;

  // Entry 0 is reset to zero and never written, so it always reads as zero.
  assign w_escreve = Escrita && (EndEscrita != c_end_zero);

  function automatic logic [LARGURA-1:0] ler(
    input logic [ENDW-1:0]    a,
    input logic               esc,
    input logic [ENDW-1:0]    end_esc,
    input logic [LARGURA-1:0] dado,
    input logic [LARGURA-1:0] armazenado
  );
    logic [LARGURA-1:0] v;
    v = armazenado;
    if (a == '0)
      v = '0;
    else if (esc && (end_esc == a))
      v = dado;
    return v;
  endfunction

  always_comb begin
    w_val1 = ler(EndLeitura1, Escrita, EndEscrita, DadoEscrita, r_regs[EndLeitura1]);
    w_val2 = ler(EndLeitura2, Escrita, EndEscrita, DadoEscrita, r_regs[EndLeitura2]);
  end

  // Overflow compares the result sign against the operands currently presented to the adder.
  assign w_ovf = (r_op1[LARGURA-1] == r_op2[LARGURA-1]) &&
                 (DadoEscrita[LARGURA-1] != r_op1[LARGURA-1]);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (w_escreve) begin
      r_regs[EndEscrita] <= DadoEscrita;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_validos <= 1'b0;
    end else begin
      r_validos <= LeituraEn;
      if (LeituraEn) begin
        r_op1 <= w_val1;
        r_op2 <= w_val2;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (FlagsEn) begin
      r_zero <= (DadoEscrita == '0);
      r_neg  <= DadoEscrita[LARGURA-1];
      r_ovf  <= w_ovf;
    end
  end

  assign Operando1        = r_op1;
  assign Operando2        = r_op2;
  assign OperandosValidos = r_validos;
  assign FlagZero         = r_zero;
  assign FlagNegativo     = r_neg;
  assign FlagOverflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_banco_registradores.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_banco_registradores: directed and random checks of the register   |
// | file against a behavioural model. Rev 1.0                            |
// +----------------------------------------------------------------------+
module tb_banco_registradores;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [2:0] EndLeitura1, EndLeitura2, EndEscrita;
  logic       LeituraEn, Escrita, FlagsEn;
  logic [7:0] DadoEscrita;
  logic [7:0] Operando1, Operando2;
  logic       OperandosValidos, FlagZero, FlagNegativo, FlagOverflow;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] m_mem [8];
  logic [7:0] m_op1, m_op2;
  logic       m_v, m_z, m_n, m_o;

  always #5 Clock = ~Clock;

  banco_registradores #(.LARGURA(8), .NREG(8), .ENDW(3)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .EndLeitura1(EndLeitura1), .EndLeitura2(EndLeitura2), .LeituraEn(LeituraEn),
    .EndEscrita(EndEscrita), .Escrita(Escrita), .DadoEscrita(DadoEscrita),
    .FlagsEn(FlagsEn),
    .Operando1(Operando1), .Operando2(Operando2), .OperandosValidos(OperandosValidos),
    .FlagZero(FlagZero), .FlagNegativo(FlagNegativo), .FlagOverflow(FlagOverflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_op1"}, Operando1, m_op1);
    chk({tag, "_op2"}, Operando2, m_op2);
    chk({tag, "_valid"}, {7'd0, OperandosValidos}, {7'd0, m_v});
    chk({tag, "_zero"}, {7'd0, FlagZero}, {7'd0, m_z});
    chk({tag, "_neg"}, {7'd0, FlagNegativo}, {7'd0, m_n});
    chk({tag, "_ovf"}, {7'd0, FlagOverflow}, {7'd0, m_o});
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_op1 = 8'h00; m_op2 = 8'h00;
    m_v = 1'b0; m_z = 1'b0; m_n = 1'b0; m_o = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    if (Escrita && EndEscrita == a) return DadoEscrita;
    return m_mem[a];
  endfunction

  // Applies the architectural effect of one rising edge to the model.
  task automatic model_edge();
    logic [7:0] v1, v2;
    v1 = model_read(EndLeitura1);
    v2 = model_read(EndLeitura2);
    if (FlagsEn) begin
      m_z = (DadoEscrita == 8'h00);
      m_n = ($signed(DadoEscrita) < 0);
      m_o = (($signed(m_op1) < 0) == ($signed(m_op2) < 0)) &&
            (($signed(DadoEscrita) < 0) != ($signed(m_op1) < 0));
    end
    if (LeituraEn) begin
      m_op1 = v1;
      m_op2 = v2;
    end
    m_v = LeituraEn;
    if (Escrita && EndEscrita != 3'd0) m_mem[EndEscrita] = DadoEscrita;
  endtask

  task automatic set_in(input logic esc, input logic [2:0] ew, input logic [7:0] d,
                        input logic fe, input logic lei, input logic [2:0] a1,
                        input logic [2:0] a2);
    Escrita = esc; EndEscrita = ew; DadoEscrita = d; FlagsEn = fe;
    LeituraEn = lei; EndLeitura1 = a1; EndLeitura2 = a2;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge Clock);
    #1;
    check_model(tag);
  endtask

  initial begin
    Resetn = 1'b0;
    set_in(0, 0, 8'h00, 0, 0, 0, 0);
    clear_model();
    #12;
    check_model("reset");
    @(posedge Clock); #1;
    Resetn = 1'b1;

    // Mid-run reset discards a pending write and capture, and clears R3.
    set_in(1, 3, 8'h55, 0, 0, 0, 0); tick("w_r3");
    set_in(1, 3, 8'hAA, 1, 1, 3, 3); tick("cap_r3");
    chk("r3_before_reset", Operando1, 8'hAA);
    set_in(1, 6, 8'h33, 1, 1, 3, 6);
    #2 Resetn = 1'b0;
    #1 clear_model();
    check_model("rst_async");
    @(posedge Clock); #1;
    check_model("rst_hold");
    Resetn = 1'b1;
    set_in(0, 0, 8'h00, 0, 1, 3, 6); tick("cap_after_rst");
    chk("r3_after_rst", Operando1, 8'h00);

    set_in(1, 2, 8'h05, 0, 0, 0, 0); tick("w_r2");
    set_in(1, 5, 8'hFD, 0, 0, 0, 0); tick("w_r5");
    set_in(0, 0, 8'h00, 0, 1, 2, 5); tick("cap_2_5");
    chk("op1_r2", Operando1, 8'h05);
    chk("op2_r5", Operando2, 8'hFD);
    chk("valid_one", {7'd0, OperandosValidos}, 8'h01);
    set_in(0, 0, 8'h00, 0, 0, 1, 1); tick("hold");
    chk("valid_drop", {7'd0, OperandosValidos}, 8'h00);
    chk("op1_hold", Operando1, 8'h05);

    set_in(1, 4, 8'h7A, 0, 1, 4, 0); tick("bypass");
    chk("bypass_op1", Operando1, 8'h7A);
    chk("bypass_op2", Operando2, 8'h00);

    set_in(1, 0, 8'hFF, 0, 0, 0, 0); tick("w_r0");
    set_in(0, 0, 8'h00, 0, 1, 0, 0); tick("cap_r0");
    chk("r0_read", Operando1, 8'h00);
    set_in(1, 0, 8'hFF, 0, 1, 0, 4); tick("bypass_r0");
    chk("r0_bypass", Operando1, 8'h00);

    set_in(1, 1, 8'h70, 0, 0, 0, 0); tick("w_r1");
    set_in(1, 2, 8'h20, 0, 0, 0, 0); tick("w_r2b");
    set_in(0, 0, 8'h00, 0, 1, 1, 2); tick("cap_70_20");
    set_in(1, 3, 8'h90, 1, 0, 0, 0); tick("flags_ovf");
    chk("ovf_set", {7'd0, FlagOverflow}, 8'h01);
    chk("neg_set", {7'd0, FlagNegativo}, 8'h01);
    chk("zero_clr", {7'd0, FlagZero}, 8'h00);

    set_in(1, 1, 8'h01, 0, 0, 0, 0); tick("w_r1b");
    set_in(1, 2, 8'hFF, 0, 0, 0, 0); tick("w_r2c");
    set_in(0, 0, 8'h00, 0, 1, 1, 2); tick("cap_01_ff");
    set_in(1, 0, 8'h00, 1, 0, 0, 0); tick("flags_zero");
    chk("zero_set", {7'd0, FlagZero}, 8'h01);
    chk("ovf_clr", {7'd0, FlagOverflow}, 8'h00);
    set_in(1, 7, 8'h80, 0, 0, 0, 0); tick("flags_hold");
    chk("zero_hold", {7'd0, FlagZero}, 8'h01);

    // Flags see operands 0x01/0xFF while R6 is captured through the bypass.
    set_in(1, 6, 8'h80, 1, 1, 6, 3); tick("cap_and_flag");
    chk("same_edge_ovf", {7'd0, FlagOverflow}, 8'h00);
    chk("same_edge_op1", Operando1, 8'h80);
    chk("same_edge_op2", Operando2, 8'h90);
    set_in(1, 5, 8'h00, 1, 0, 0, 0); tick("flag_new_ops");
    chk("new_ops_ovf", {7'd0, FlagOverflow}, 8'h01);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      set_in(1'($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), d,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/banco_registradores.md
# banco_registradores

Eight-entry signed register file with a registered operand stage, sitting directly upstream of the 8-bit signed adder (`Somador`) in the datapath.
- Captured operands drive the adder inputs.
- The adder's result returns on the write port.
- A status-flag register is updated from that write-back.
- R0 reads as constant zero.

## Interface

Parameters:
- LARGURA, 8, data width of registers, operands and write data (two's complement).
- NREG, 8, number of registers; power of two, ≥ 2.
- ENDW, 3, address width; must equal log2(NREG).

Ports (clock is single; reset is asynchronous and active-low):
- Clock  input  1  single rising-edge clock for all state.
- Resetn  input  1  asynchronous, active-low reset.
- EndLeitura1  input  ENDW  address for operand 1.
- EndLeitura2  input  ENDW  address for operand 2.
- LeituraEn  input  1  capture both operands on this edge.
- EndEscrita  input  ENDW  write address.
- Escrita  input  1  write enable.
- DadoEscrita  input  LARGURA  signed write data (adder result).
- FlagsEn  input  1  update flags from this write.
- Operando1  output  LARGURA  registered operand 1, to adder Entrada1.
- Operando2  output  LARGURA  registered operand 2, to adder Entrada2.
- OperandosValidos  output  1  Operando1/2 were captured on the last edge.
- FlagZero  output  1  last flagged write data was zero.
- FlagNegativo  output  1  last flagged write data had MSB set.
- FlagOverflow  output  1  last flagged write was a signed-add overflow.

## Operation

- **Storage:** NREG × LARGURA registers.
  - R0 is hardwired to 0; writes to address 0 are discarded.
- **Write:** on a rising edge with Escrita=1 and EndEscrita≠0, register[EndEscrita] ← DadoEscrita.
- **Operand capture:** on a rising edge with LeituraEn=1, OperandoN ← value(EndLeituraN).
  - value(a) = 0 if a = 0.
  - Otherwise, if Escrita=1 and EndEscrita = a, value(a) = DadoEscrita (write-first bypass).
  - Otherwise, value(a) = register[a].
- **Operand hold:** with LeituraEn=0, Operando1/2 hold their values.
- **Valid flag:** OperandosValidos ← LeituraEn on every edge.
- **Flag update:** on a rising edge with FlagsEn=1:
  - FlagZero ← (DadoEscrita == 0).
  - FlagNegativo ← DadoEscrita[LARGURA-1].
  - FlagOverflow ← (Operando1[MSB] == Operando2[MSB]) && (DadoEscrita[MSB] != Operando1[MSB]), using pre-edge operand values.
  - FlagsEn is independent of Escrita and EndEscrita; flags update even when the target is R0.
  - With FlagsEn=0, flags hold.
- **Same-edge events:** LeituraEn and FlagsEn asserted together are both honoured; flags use the old operands and the operands load new values.

## Timing

- **Reset (Resetn=0, asynchronous):**
  - All registers = 0.
  - Operando1 = Operando2 = 0.
  - OperandosValidos = 0.
  - All flags = 0.
  - Reset holds while Resetn=0; normal operation resumes on the first rising edge after Resetn=1.
  - Reset asserted mid-operation discards any same-cycle write or capture.
- **Latency:**
  - Register write is visible to capture one edge later, or on the same edge via bypass.
  - Operands appear one cycle after the capture edge.
  - Flags appear one cycle after the FlagsEn edge.
- **Typical loop:**
  - Edge N: LeituraEn captures the operands.
  - Cycle N→N+1: the adder settles combinationally.
  - Edge N+1: Escrita+FlagsEn write the result back. A LeituraEn on this edge reading the destination receives the new result via bypass.
- **Combinational paths:** no combinational path from inputs to outputs; all outputs are registered.
- **Address aliasing:** identical EndLeitura1 and EndLeitura2 are legal; both operands get the same value.

## Test plan

- **Reset:** Resetn low mid-run after writing R3=0x55 → all outputs 0 immediately; after release, capturing R3 gives 0x00.
- **Write then capture:** write R2=0x05 and R5=0xFD; next edge LeituraEn with addresses 2,5 → Operando1=0x05, Operando2=0xFD, OperandosValidos=1 for one cycle.
- **Bypass:** same edge Escrita R4=0x7A and LeituraEn reading R4/R0 → Operando1=0x7A, Operando2=0x00.
- **R0 protection:** write R0=0xFF, then capture R0 → 0x00; a bypass to address 0 is also blocked.
- **Flags:**
  - Operands 0x70,0x20, write 0x90 with FlagsEn → Overflow=1, Negativo=1, Zero=0.
  - Operands 0x01,0xFF, write 0x00 → Zero=1, Overflow=0.
  - FlagsEn=0 on the next write → flags unchanged.
- **Simultaneous capture and flag:** LeituraEn and FlagsEn on the same edge → flags are computed from the previous operands and the new operands appear next cycle.
